// File: rtl/lfsr_rand_sched.sv
// Round-robin scheduler handing out words from a 32-bit Galois LFSR, with seeding and warm-up.
// Build option: define LFSR_FREE_RUN_EN to step the LFSR every SERVE cycle instead of only on grants.
module lfsr_rand_sched #(
    parameter int          NUM_REQ = 4,
    parameter logic [31:0] SEED    = 32'h0000_0001,
    parameter logic [31:0] POLY    = 32'h8020_0003,
    parameter int          WARMUP  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seed_load,
    input  logic [31:0]        seed_val,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_data,
    output logic               ready,
    output logic               seed_zero
);
    // state | meaning
    // WARM  | discarding WARMUP LFSR steps after reset or seed load, no grants
    // SERVE | arbitrating requests, one word per grant
    typedef enum logic {WARM, SERVE} state_t;

    localparam int         PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] WARM_INIT  = 8'(WARMUP);
    localparam state_t     INIT_STATE = (WARMUP == 0) ? SERVE : WARM;

    state_t             state;
    logic [31:0]        lfsr;
    logic [7:0]         warm_cnt;
    logic [PTR_W-1:0]   rr_ptr;

    logic [NUM_REQ-1:0] rot;
    logic               any_req;
    int                 off;
    logic [PTR_W:0]     sum;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   nxt_ptr;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? POLY : 32'h0);
    endfunction

    // Rotate requests so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    always_comb begin
        rot     = NUM_REQ'({req, req} >> rr_ptr);
        any_req = 1'b0;
        off     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any_req = 1'b1;
                off     = k;
            end
        end
        sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
        if (sum >= (PTR_W+1)'(NUM_REQ))
            sum = sum - (PTR_W+1)'(NUM_REQ);
        sel     = sum[PTR_W-1:0];
        nxt_ptr = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr      <= SEED;
            state     <= INIT_STATE;
            warm_cnt  <= WARM_INIT;
            rr_ptr    <= '0;
            gnt       <= '0;
            rnd_data  <= '0;
            ready     <= 1'b0;
            seed_zero <= 1'b0;
        end else begin
            gnt       <= '0;
            seed_zero <= 1'b0;
            if (seed_load) begin
                lfsr      <= (seed_val == 32'h0) ? SEED : seed_val;
                seed_zero <= (seed_val == 32'h0);
                warm_cnt  <= WARM_INIT;
                state     <= INIT_STATE;
                ready     <= (WARMUP == 0);
            end else begin
                case (state)
                    WARM: begin
                        lfsr     <= lfsr_step(lfsr);
                        warm_cnt <= warm_cnt - 8'd1;
                        ready    <= 1'b0;
                        if (warm_cnt <= 8'd1) begin
                            state <= SERVE;
                            ready <= 1'b1;
                        end
                    end
                    SERVE: begin
                        ready <= 1'b1;
                        if (any_req) begin
                            gnt      <= NUM_REQ'(1) << sel;
                            rnd_data <= lfsr;
                            rr_ptr   <= nxt_ptr;
                        end
`ifdef LFSR_FREE_RUN_EN
                        lfsr <= lfsr_step(lfsr);
`else
                        if (any_req)
                            lfsr <= lfsr_step(lfsr);
`endif
                    end
                    default: state <= WARM;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lfsr_rand_sched.sv
// Self-checking bench for lfsr_rand_sched: one instance with WARMUP=0, one with WARMUP=8.
module tb_lfsr_rand_sched;
    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;
`ifdef LFSR_FREE_RUN_EN
    localparam bit FREE = 1'b1;
`else
    localparam bit FREE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, seed_load0 = 1'b0, ready0, sz0;
    logic [31:0] seed_val0 = '0, rnd0;
    logic [3:0]  req0 = '0, gnt0;

    logic        rst8 = 1'b1, seed_load8 = 1'b0, ready8, sz8;
    logic [31:0] seed_val8 = '0, rnd8;
    logic [3:0]  req8 = '0, gnt8;

    lfsr_rand_sched #(.NUM_REQ(4), .SEED(SEED), .POLY(POLY), .WARMUP(0)) dut0 (
        .clk(clk), .reset(rst0), .seed_load(seed_load0), .seed_val(seed_val0),
        .req(req0), .gnt(gnt0), .rnd_data(rnd0), .ready(ready0), .seed_zero(sz0));

    lfsr_rand_sched #(.NUM_REQ(4), .SEED(SEED), .POLY(POLY), .WARMUP(8)) dut8 (
        .clk(clk), .reset(rst8), .seed_load(seed_load8), .seed_val(seed_val8),
        .req(req8), .gnt(gnt8), .rnd_data(rnd8), .ready(ready8), .seed_zero(sz8));

    int checks = 0;
    int errors = 0;

    // Reference model for dut0: next word to hand out, last word delivered, round-robin pointer.
    logic [31:0] m_lfsr, m_rnd;
    int          m_ptr;
    logic [3:0]  exp_gnt;
    logic        exp_sz;

    function automatic logic [31:0] nxt(input logic [31:0] v);
        if (v[0]) return (v >> 1) ^ POLY;
        return v >> 1;
    endfunction

    function automatic logic [31:0] advance(input logic [31:0] v, input int n);
        logic [31:0] t = v;
        for (int i = 0; i < n; i++) t = nxt(t);
        return t;
    endfunction

    task automatic m_reset0();
        m_lfsr = SEED;
        m_rnd  = 32'h0;
        m_ptr  = 0;
    endtask

    // Drives one cycle into dut0 and advances the model; checks are done by the callers.
    task automatic drive0(input logic [3:0] r, input logic sl, input logic [31:0] sv);
        bit found;
        req0 = r; seed_load0 = sl; seed_val0 = sv;
        @(posedge clk); #1;
        seed_load0 = 1'b0;
        exp_gnt = 4'b0;
        exp_sz  = 1'b0;
        found   = 1'b0;
        if (sl) begin
            m_lfsr = (sv == 32'h0) ? SEED : sv;
            exp_sz = (sv == 32'h0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    found = 1'b1;
                    exp_gnt[(m_ptr + k) % 4] = 1'b1;
                    m_ptr = ((m_ptr + k) % 4 + 1) % 4;
                end
            end
            if (found) m_rnd = m_lfsr;
            if (found || FREE) m_lfsr = nxt(m_lfsr);
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst8 = 1'b1;
        @(posedge clk); #1;
        checks++; if (gnt0 !== 4'b0)  begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt0); end
        checks++; if (rnd0 !== 32'h0) begin errors++; $display("FAIL reset_rnd: got %h expected 00000000", rnd0); end
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready0); end
        checks++; if (sz0 !== 1'b0)   begin errors++; $display("FAIL reset_seed_zero: got %b expected 0", sz0); end
        checks++; if (ready8 !== 1'b0) begin errors++; $display("FAIL reset_ready8: got %b expected 0", ready8); end
    endtask

    task automatic test_single_req();
        logic [31:0] tbl [4];
        tbl[0] = 32'h0000_0001; tbl[1] = 32'h8020_0003; tbl[2] = 32'hC030_0002; tbl[3] = 32'h6018_0001;
        rst0 = 1'b1; @(posedge clk); #1; rst0 = 1'b0; m_reset0();
        for (int i = 0; i < 4; i++) begin
            drive0(4'b0001, 1'b0, 32'h0);
            checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL single_gnt[%0d]: got %b expected 0001", i, gnt0); end
            checks++; if (rnd0 !== tbl[i])  begin errors++; $display("FAIL single_rnd[%0d]: got %h expected %h", i, rnd0, tbl[i]); end
            checks++; if (ready0 !== 1'b1)  begin errors++; $display("FAIL single_ready[%0d]: got %b expected 1", i, ready0); end
        end
        req0 = 4'b0;
    endtask

    task automatic test_all_req();
        rst0 = 1'b1; @(posedge clk); #1; rst0 = 1'b0; m_reset0();
        for (int i = 0; i < 5; i++) begin
            drive0(4'b1111, 1'b0, 32'h0);
            checks++; if (gnt0 !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt0, exp_gnt); end
            checks++; if (gnt0 !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL rr_order[%0d]: got %b expected index %0d", i, gnt0, i % 4); end
            checks++; if (rnd0 !== m_rnd) begin errors++; $display("FAIL rr_rnd[%0d]: got %h expected %h", i, rnd0, m_rnd); end
        end
        req0 = 4'b0;
    endtask

    task automatic test_seed_zero();
        drive0(4'b1111, 1'b1, 32'h0);
        checks++; if (gnt0 !== 4'b0) begin errors++; $display("FAIL seedz_gnt: got %b expected 0000", gnt0); end
        checks++; if (sz0 !== 1'b1)  begin errors++; $display("FAIL seedz_pulse: got %b expected 1", sz0); end
        drive0(4'b1111, 1'b0, 32'h0);
        checks++; if (sz0 !== 1'b0)  begin errors++; $display("FAIL seedz_clear: got %b expected 0", sz0); end
        checks++; if (gnt0 !== exp_gnt) begin errors++; $display("FAIL seedz_gnt2: got %b expected %b", gnt0, exp_gnt); end
        checks++; if (rnd0 !== 32'h0000_0001) begin errors++; $display("FAIL seedz_rnd: got %h expected 00000001", rnd0); end
        req0 = 4'b0;
    endtask

    task automatic test_random();
        logic [3:0]  r;
        logic        sl;
        logic [31:0] sv;
        for (int i = 0; i < 120; i++) begin
            r  = 4'($urandom_range(0, 15));
            sl = ($urandom_range(0, 11) == 0);
            sv = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            drive0(r, sl, sv);
            checks++; if (gnt0 !== exp_gnt) begin errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", i, gnt0, exp_gnt); end
            checks++; if (rnd0 !== m_rnd)   begin errors++; $display("FAIL rand_rnd[%0d]: got %h expected %h", i, rnd0, m_rnd); end
            checks++; if (sz0 !== exp_sz)   begin errors++; $display("FAIL rand_seed_zero[%0d]: got %b expected %b", i, sz0, exp_sz); end
            checks++; if (ready0 !== 1'b1)  begin errors++; $display("FAIL rand_ready[%0d]: got %b expected 1", i, ready0); end
        end
        req0 = 4'b0;
    endtask

    task automatic test_warmup();
        logic [31:0] exp_v;
        rst8 = 1'b1; req8 = 4'b0010;
        @(posedge clk); #1; rst8 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            checks++; if (gnt8 !== 4'b0) begin errors++; $display("FAIL warm_gnt[%0d]: got %b expected 0000", e, gnt8); end
            checks++; if (ready8 !== (e == 8)) begin errors++; $display("FAIL warm_ready[%0d]: got %b expected %b", e, ready8, (e == 8)); end
        end
        @(posedge clk); #1;
        exp_v = advance(SEED, 8);
        checks++; if (gnt8 !== 4'b0010) begin errors++; $display("FAIL warm_first_gnt: got %b expected 0010", gnt8); end
        checks++; if (rnd8 !== exp_v)   begin errors++; $display("FAIL warm_first_rnd: got %h expected %h", rnd8, exp_v); end
        req8 = 4'b0001; seed_load8 = 1'b1; seed_val8 = 32'hDEAD_BEEF;
        @(posedge clk); #1; seed_load8 = 1'b0;
        checks++; if (gnt8 !== 4'b0)  begin errors++; $display("FAIL reload_gnt: got %b expected 0000", gnt8); end
        checks++; if (ready8 !== 1'b0) begin errors++; $display("FAIL reload_ready: got %b expected 0", ready8); end
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            checks++; if (gnt8 !== 4'b0) begin errors++; $display("FAIL reload_warm_gnt[%0d]: got %b expected 0000", e, gnt8); end
        end
        @(posedge clk); #1;
        exp_v = advance(32'hDEAD_BEEF, 8);
        checks++; if (gnt8 !== 4'b0001) begin errors++; $display("FAIL reload_first_gnt: got %b expected 0001", gnt8); end
        checks++; if (rnd8 !== exp_v)   begin errors++; $display("FAIL reload_first_rnd: got %h expected %h", rnd8, exp_v); end
        req8 = 4'b0;
    endtask

    task automatic test_async_reset();
        rst0 = 1'b1; @(posedge clk); #1; rst0 = 1'b0; m_reset0();
        drive0(4'b0100, 1'b0, 32'h0);
        drive0(4'b0100, 1'b0, 32'h0);
        checks++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL async_pre_gnt: got %b expected 0100", gnt0); end
        #2 rst0 = 1'b1;
        #1;
        checks++; if (gnt0 !== 4'b0)   begin errors++; $display("FAIL async_gnt: got %b expected 0000", gnt0); end
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL async_ready: got %b expected 0", ready0); end
        checks++; if (rnd0 !== 32'h0)  begin errors++; $display("FAIL async_rnd: got %h expected 00000000", rnd0); end
        @(posedge clk); #1; rst0 = 1'b0; m_reset0();
        drive0(4'b0100, 1'b0, 32'h0);
        checks++; if (gnt0 !== 4'b0100) begin errors++; $display("FAIL async_restart_gnt: got %b expected 0100", gnt0); end
        checks++; if (rnd0 !== SEED)    begin errors++; $display("FAIL async_restart_rnd: got %h expected %h", rnd0, SEED); end
        req0 = 4'b0;
    endtask

`ifdef LFSR_FREE_RUN_EN
    task automatic test_free_run();
        rst0 = 1'b1; @(posedge clk); #1; rst0 = 1'b0; m_reset0();
        for (int i = 0; i < 3; i++) drive0(4'b0000, 1'b0, 32'h0);
        drive0(4'b0001, 1'b0, 32'h0);
        checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL free_gnt: got %b expected 0001", gnt0); end
        checks++; if (rnd0 !== 32'h6018_0001) begin errors++; $display("FAIL free_rnd: got %h expected 60180001", rnd0); end
        req0 = 4'b0;
    endtask
`endif

    initial begin
        m_reset0();
        exp_gnt = '0;
        exp_sz  = 1'b0;
        test_reset();
        test_single_req();
        test_all_req();
        test_seed_zero();
        test_random();
        test_warmup();
        test_async_reset();
`ifdef LFSR_FREE_RUN_EN
        test_free_run();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
